// File: rtl/bram_copy_engine.sv
// Forward block copy over one bram port: read, capture, write per word (3 cycles/word).
// Done pulses one cycle after the last write; zero-length copies finish one cycle after start.
module bram_copy_engine #(
    parameter int P_DATA_WIDTH    = 16,
    parameter int P_ADDRESS_WIDTH = 10
) (
    input  logic                       I_CLK,
    input  logic                       I_RESET,
    input  logic                       I_START,
    input  logic [P_ADDRESS_WIDTH-1:0] I_SRC_ADDR,
    input  logic [P_ADDRESS_WIDTH-1:0] I_DST_ADDR,
    input  logic [P_ADDRESS_WIDTH:0]   I_LENGTH,
    output logic                       O_BUSY,
    output logic                       O_DONE,
    output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS,
    output logic [P_DATA_WIDTH-1:0]    O_MEM_DATA,
    output logic                       O_MEM_WRITE_ENABLE,
    input  logic [P_DATA_WIDTH-1:0]    I_MEM_DATA
);

    localparam int AW = P_ADDRESS_WIDTH;
    localparam int DW = P_DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   src_q, dst_q, last_addr_q;
    logic [AW:0]     remain_q;
    logic [DW-1:0]   data_q;

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            remain_q    <= '0;
            data_q      <= '0;
            last_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            // Lets the address bus hold its previous value while idle.
            last_addr_q <= O_MEM_ADDRESS;
            case (state_q)
                S_IDLE: begin
                    if (I_START) begin
                        src_q    <= I_SRC_ADDR;
                        dst_q    <= I_DST_ADDR;
                        remain_q <= I_LENGTH;
                    end
                end
                S_CAPTURE: data_q <= I_MEM_DATA;
                S_WRITE: begin
                    src_q    <= src_q + AW'(1);
                    dst_q    <= dst_q + AW'(1);
                    remain_q <= remain_q - (AW+1)'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d            = state_q;
        O_BUSY             = 1'b0;
        O_DONE             = 1'b0;
        O_MEM_ADDRESS      = last_addr_q;
        O_MEM_DATA         = '0;
        O_MEM_WRITE_ENABLE = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (I_START) state_d = (I_LENGTH != '0) ? S_READ : S_DONE;
            end
            S_READ: begin
                O_BUSY        = 1'b1;
                O_MEM_ADDRESS = src_q;
                state_d       = S_CAPTURE;
            end
            S_CAPTURE: begin
                O_BUSY        = 1'b1;
                O_MEM_ADDRESS = src_q;
                state_d       = S_WRITE;
            end
            S_WRITE: begin
                O_BUSY             = 1'b1;
                O_MEM_ADDRESS      = dst_q;
                O_MEM_DATA         = data_q;
                O_MEM_WRITE_ENABLE = 1'b1;
                state_d            = (remain_q > (AW+1)'(1)) ? S_READ : S_DONE;
            end
            S_DONE: begin
                O_DONE  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bram_copy_engine.sv
// Bench for bram_copy_engine: local dual-port memory, cycle-level reference model, directed copies.
module tb_bram_copy_engine;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int MEMSZ = 1 << AW;

    logic          I_CLK = 1'b0;
    logic          I_RESET = 1'b1;
    logic          I_START = 1'b0;
    logic [AW-1:0] I_SRC_ADDR = '0;
    logic [AW-1:0] I_DST_ADDR = '0;
    logic [AW:0]   I_LENGTH = '0;
    logic          O_BUSY, O_DONE, O_MEM_WRITE_ENABLE;
    logic [AW-1:0] O_MEM_ADDRESS;
    logic [DW-1:0] O_MEM_DATA;
    logic [DW-1:0] I_MEM_DATA = '0;

    int checks = 0;
    int failures = 0;

    bram_copy_engine #(.P_DATA_WIDTH(DW), .P_ADDRESS_WIDTH(AW)) dut (
        .I_CLK(I_CLK), .I_RESET(I_RESET), .I_START(I_START),
        .I_SRC_ADDR(I_SRC_ADDR), .I_DST_ADDR(I_DST_ADDR), .I_LENGTH(I_LENGTH),
        .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_MEM_ADDRESS(O_MEM_ADDRESS),
        .O_MEM_DATA(O_MEM_DATA), .O_MEM_WRITE_ENABLE(O_MEM_WRITE_ENABLE),
        .I_MEM_DATA(I_MEM_DATA)
    );

    always #5 I_CLK = ~I_CLK;

    // Memory: port B is the DUT, port A is the bench (write-only here; reads are direct).
    logic [DW-1:0] mem [0:MEMSZ-1];
    logic          pa_we = 1'b0;
    logic [AW-1:0] pa_addr = '0;
    logic [DW-1:0] pa_dat = '0;

    always @(posedge I_CLK) begin
        if (pa_we) mem[pa_addr] <= pa_dat;
        if (O_MEM_WRITE_ENABLE) mem[O_MEM_ADDRESS] <= O_MEM_DATA;
        I_MEM_DATA <= mem[O_MEM_ADDRESS];
    end

    // Reference model: position within a copy is derived arithmetically from cycles since acceptance.
    logic [DW-1:0] ref_mem [0:MEMSZ-1];
    int            m_k = 0, m_n = 0, m_src = 0, m_dst = 0;
    bit            model_live = 0, addr_known = 0;
    bit            exp_busy = 0, exp_done = 0, exp_we = 0, exp_idle = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_dat = '0;

    always @(posedge I_CLK) begin
        int i, ph;
        if (pa_we) ref_mem[pa_addr] = pa_dat;
        if (exp_we) ref_mem[exp_addr] = exp_dat;
        if (I_RESET) begin
            model_live = 1; m_k = 0; m_n = 0;
            exp_busy = 0; exp_done = 0; exp_we = 0; exp_dat = '0;
            exp_addr = '0; addr_known = 1; exp_idle = 1;
        end else if (model_live) begin
            if (m_k == 0) begin
                if (I_START) begin
                    m_src = int'(I_SRC_ADDR); m_dst = int'(I_DST_ADDR);
                    m_n = int'(I_LENGTH); m_k = 1;
                end
            end else if (m_k == 3 * m_n + 1) m_k = 0;
            else m_k++;
            exp_busy = 0; exp_done = 0; exp_we = 0; exp_dat = '0;
            exp_idle = (m_k == 0);
            if (m_k != 0 && m_k <= 3 * m_n) begin
                i = (m_k - 1) / 3;
                ph = (m_k - 1) % 3;
                exp_busy = 1;
                addr_known = 1;
                exp_addr = AW'(((ph == 2) ? m_dst + i : m_src + i) % MEMSZ);
                if (ph == 2) begin
                    exp_we = 1;
                    exp_dat = ref_mem[(m_src + i) % MEMSZ];
                end
            end else if (m_k != 0) begin
                exp_done = 1;
                addr_known = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    always @(negedge I_CLK) begin
        if (model_live) begin
            chk("busy", 32'(O_BUSY), 32'(exp_busy));
            chk("done", 32'(O_DONE), 32'(exp_done));
            chk("write_enable", 32'(O_MEM_WRITE_ENABLE), 32'(exp_we));
            if (exp_busy || addr_known) chk("address", 32'(O_MEM_ADDRESS), 32'(exp_addr));
            if (exp_we || exp_idle) chk("write_data", 32'(O_MEM_DATA), 32'(exp_dat));
        end
    end

    // Caller is at a negedge; each poke takes one cycle.
    task automatic poke(input int a, input int d);
        pa_we = 1'b1; pa_addr = AW'(a); pa_dat = DW'(d);
        @(negedge I_CLK);
        pa_we = 1'b0;
    endtask

    // Returns at the negedge of the first cycle after acceptance, with inputs scrambled.
    task automatic start_copy(input int s, input int d, input int n);
        I_START = 1'b1; I_SRC_ADDR = AW'(s); I_DST_ADDR = AW'(d); I_LENGTH = (AW+1)'(n);
        @(negedge I_CLK);
        I_START = 1'b0;
        I_SRC_ADDR = AW'($urandom); I_DST_ADDR = AW'($urandom); I_LENGTH = (AW+1)'($urandom);
    endtask

    task automatic observe(input int ncyc, input int pulse_at, input int reset_at,
                           output int busy_cnt, output int done_at, output int done_cnt);
        busy_cnt = 0; done_at = 0; done_cnt = 0;
        for (int c = 1; c <= ncyc; c++) begin
            if (c > 1) @(negedge I_CLK);
            if (pulse_at != 0 && c == pulse_at) begin
                I_START = 1'b1; I_SRC_ADDR = 10'h300; I_DST_ADDR = 10'h380; I_LENGTH = 11'd2;
            end
            if (pulse_at != 0 && c == pulse_at + 1) I_START = 1'b0;
            if (reset_at != 0 && c == reset_at) I_RESET = 1'b1;
            if (reset_at != 0 && c == reset_at + 1) begin
                I_RESET = 1'b0;
                chk("post_reset_address", 32'(O_MEM_ADDRESS), 32'h0);
                chk("post_reset_busy", 32'(O_BUSY), 32'h0);
            end
            if (O_BUSY) busy_cnt++;
            if (O_DONE) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
        end
    endtask

    initial begin
        int bc, da, dc, bad;
        @(negedge I_CLK);
        for (int a = 0; a < MEMSZ; a++) poke(a, 16'hC000 ^ a);
        chk("reset_busy", 32'(O_BUSY), 32'h0);
        chk("reset_done", 32'(O_DONE), 32'h0);
        chk("reset_address", 32'(O_MEM_ADDRESS), 32'h0);
        chk("reset_data", 32'(O_MEM_DATA), 32'h0);
        I_RESET = 1'b0;
        @(negedge I_CLK);

        // Basic copy, with an ignored start pulse while busy.
        for (int a = 0; a < 8; a++) poke(a, a + 1);
        start_copy(0, 16'h100, 8);
        observe(40, 6, 0, bc, da, dc);
        chk("t1_busy_cycles", 32'(bc), 32'd24);
        chk("t1_done_cycle", 32'(da), 32'd25);
        chk("t1_done_count", 32'(dc), 32'd1);
        for (int a = 0; a < 8; a++) begin
            chk("t1_dst", 32'(mem[16'h100 + a]), 32'(a + 1));
            chk("t1_src", 32'(mem[a]), 32'(a + 1));
        end
        chk("t5_ignored_380", 32'(mem[10'h380]), 32'hC380);
        chk("t5_ignored_381", 32'(mem[10'h381]), 32'hC381);

        // Zero length.
        start_copy(0, 16'h100, 0);
        observe(10, 0, 0, bc, da, dc);
        chk("t2_busy_cycles", 32'(bc), 32'd0);
        chk("t2_done_cycle", 32'(da), 32'd1);
        chk("t2_dst_unchanged", 32'(mem[10'h100]), 32'd1);

        // Source wrap, then destination wrap.
        poke(10'h3FE, 16'hAAAA); poke(10'h3FF, 16'hBBBB); poke(0, 1); poke(1, 2);
        start_copy(10'h3FE, 10'h200, 4);
        observe(20, 0, 0, bc, da, dc);
        chk("t3_done_cycle", 32'(da), 32'd13);
        chk("t3_200", 32'(mem[10'h200]), 32'hAAAA);
        chk("t3_201", 32'(mem[10'h201]), 32'hBBBB);
        chk("t3_202", 32'(mem[10'h202]), 32'h1);
        chk("t3_203", 32'(mem[10'h203]), 32'h2);
        poke(10'h010, 16'h1234); poke(10'h011, 16'h5678);
        start_copy(10'h010, 10'h3FF, 2);
        observe(12, 0, 0, bc, da, dc);
        chk("t3_dst_3ff", 32'(mem[10'h3FF]), 32'h1234);
        chk("t3_dst_000", 32'(mem[0]), 32'h5678);

        // Forward overlap replicates the first word.
        for (int a = 0; a < 5; a++) poke(a, a + 1);
        start_copy(0, 1, 4);
        observe(16, 0, 0, bc, da, dc);
        for (int a = 0; a < 5; a++) chk("t4_overlap", 32'(mem[a]), 32'h1);

        // Reset in the 8th cycle of a copy, then a clean rerun.
        for (int a = 0; a < 8; a++) begin poke(a, a + 1); poke(16'h100 + a, 16'hDEAD); end
        start_copy(0, 16'h100, 8);
        observe(40, 0, 8, bc, da, dc);
        chk("t6_busy_cycles", 32'(bc), 32'd8);
        chk("t6_no_done", 32'(dc), 32'd0);
        chk("t6_100", 32'(mem[10'h100]), 32'h1);
        chk("t6_101", 32'(mem[10'h101]), 32'h2);
        chk("t6_102", 32'(mem[10'h102]), 32'hDEAD);
        chk("t6_107", 32'(mem[10'h107]), 32'hDEAD);
        start_copy(0, 16'h100, 8);
        observe(30, 0, 0, bc, da, dc);
        chk("t6_rerun_done_cycle", 32'(da), 32'd25);
        for (int a = 0; a < 8; a++) chk("t6_rerun_dst", 32'(mem[16'h100 + a]), 32'(a + 1));

        bad = 0;
        for (int a = 0; a < MEMSZ; a++) if (mem[a] !== ref_mem[a]) bad++;
        chk("memory_vs_model", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
